id_ex_controller: RTL and testbench

Registered, pipelined successor to the single-cycle R-type decoder. Decodes opcode/func for the full integer subset (R-type, immediate ALU, load/store, branch, jump) and launches the control bundle into the ID/EX pipeline register. Stall and flush inputs come from the hazard unit. Illegal encodings are trapped into a sticky status record. Sits between the IF/ID register and the execute stage.

---
 rtl/id_ex_controller.sv | 189 ++++++++++++++++++
 tb/tb_id_ex_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_controller.sv
// ID/EX control stage: decodes opcode/func into the execute control bundle
// and registers it, honouring stall/flush and trapping illegal encodings.
module id_ex_controller #(
  parameter int ALUOP_W      = 4,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               stall,
  input  logic               flush,
  output logic               ex_valid,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               ex_alusrc,
  output logic               ex_regdst,
  output logic               ex_regwrite,
  output logic               ex_readmem,
  output logic               ex_writemem,
  output logic               ex_memtoreg,
  output logic               ex_branch,
  output logic               ex_branch_ne,
  output logic               ex_jump,
  output logic               ex_zeroext,
  output logic               illegal,
  output logic [5:0]         illegal_opcode,
  output logic [5:0]         illegal_func
);

  localparam logic [ALUOP_W-1:0] ALU_NOP  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_ADDU = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SUBU = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(11);

  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic               alusrc;
    logic               regdst;
    logic               regwrite;
    logic               readmem;
    logic               writemem;
    logic               memtoreg;
    logic               branch;
    logic               branch_ne;
    logic               jump;
    logic               zeroext;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{aluop: ALU_NOP, default: 1'b0};

  ctrl_t      dec;
  logic       legal;
  ctrl_t      ctrl_d, ctrl_q;
  logic       valid_d, valid_q;
  logic       ill_d, ill_q;
  logic [5:0] ill_op_d, ill_op_q;
  logic [5:0] ill_fn_d, ill_fn_q;

  always_comb begin
    dec   = CTRL_NOP;
    legal = 1'b1;
    unique case (opcode)
      6'h00: begin
        dec.regdst   = 1'b1;
        dec.regwrite = 1'b1;
        unique case (func)
          6'h20:   dec.aluop = ALU_ADD;
          6'h21:   dec.aluop = ALU_ADDU;
          6'h22:   dec.aluop = ALU_SUB;
          6'h23:   dec.aluop = ALU_SUBU;
          6'h24:   dec.aluop = ALU_AND;
          6'h25:   dec.aluop = ALU_OR;
          6'h27:   dec.aluop = ALU_NOR;
          6'h00:   dec.aluop = ALU_SLL;
          6'h02:   dec.aluop = ALU_SRL;
          6'h03:   dec.aluop = ALU_SRA;
          6'h2A:   dec.aluop = ALU_SLT;
          default: legal     = 1'b0;
        endcase
      end
      6'h08, 6'h09, 6'h0A: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = (opcode == 6'h08) ? ALU_ADD :
                       (opcode == 6'h09) ? ALU_ADDU : ALU_SLT;
      end
      6'h0C, 6'h0D: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.zeroext  = 1'b1;
        dec.aluop    = (opcode == 6'h0C) ? ALU_AND : ALU_OR;
      end
      6'h23: begin
        dec.aluop    = ALU_ADD;
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.readmem  = 1'b1;
        dec.memtoreg = 1'b1;
      end
      6'h2B: begin
        dec.aluop    = ALU_ADD;
        dec.alusrc   = 1'b1;
        dec.writemem = 1'b1;
      end
      6'h04, 6'h05: begin
        dec.aluop     = ALU_SUB;
        dec.branch    = 1'b1;
        dec.branch_ne = opcode[0];
      end
      6'h02:   dec.jump = 1'b1;
      default: legal    = 1'b0;
    endcase
    // Illegal encodings never leak partial control bits.
    if (!legal) dec = CTRL_NOP;
  end

  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    ill_d    = ill_q;
    ill_op_d = ill_op_q;
    ill_fn_d = ill_fn_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
    end else if (stall) begin
      valid_d = valid_q;
    end else if (!id_valid) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
    end else if (legal) begin
      valid_d = 1'b1;
      ctrl_d  = dec;
    end else if (TRAP_ILLEGAL) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
      if (!ill_q) begin
        ill_d    = 1'b1;
        ill_op_d = opcode;
        ill_fn_d = (opcode == 6'h00) ? func : 6'h00;
      end
    end else begin
      valid_d = 1'b1;
      ctrl_d  = CTRL_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      ctrl_q   <= CTRL_NOP;
      ill_q    <= 1'b0;
      ill_op_q <= 6'h00;
      ill_fn_q <= 6'h00;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      ill_q    <= ill_d;
      ill_op_q <= ill_op_d;
      ill_fn_q <= ill_fn_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_aluop       = ctrl_q.aluop;
  assign ex_alusrc      = ctrl_q.alusrc;
  assign ex_regdst      = ctrl_q.regdst;
  assign ex_regwrite    = ctrl_q.regwrite;
  assign ex_readmem     = ctrl_q.readmem;
  assign ex_writemem    = ctrl_q.writemem;
  assign ex_memtoreg    = ctrl_q.memtoreg;
  assign ex_branch      = ctrl_q.branch;
  assign ex_branch_ne   = ctrl_q.branch_ne;
  assign ex_jump        = ctrl_q.jump;
  assign ex_zeroext     = ctrl_q.zeroext;
  assign illegal        = ill_q;
  assign illegal_opcode = ill_op_q;
  assign illegal_func   = ill_fn_q;

endmodule

// File: tb/tb_id_ex_controller.sv
// Scoreboard bench for id_ex_controller: expected bundle/status pushed
// with each stimulus cycle, popped and compared one edge later.
module tb_id_ex_controller;

  localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, ADDU = 4'd2, SUB = 4'd3;
  localparam logic [3:0] SUBU = 4'd4, AND = 4'd5, OR = 4'd6, NOR = 4'd7;
  localparam logic [3:0] SLL = 4'd8, SRL = 4'd9, SRA = 4'd10, SLT = 4'd11;

  // control bit order: alusrc regdst regwrite readmem writemem
  //                    memtoreg branch branch_ne jump zeroext
  localparam logic [9:0] SRC = 10'b1000000000, RDST = 10'b0100000000;
  localparam logic [9:0] RW  = 10'b0010000000, RM   = 10'b0001000000;
  localparam logic [9:0] WM  = 10'b0000100000, M2R  = 10'b0000010000;
  localparam logic [9:0] BR  = 10'b0000001000, BNE  = 10'b0000000100;
  localparam logic [9:0] JMP = 10'b0000000010, ZX   = 10'b0000000001;
  localparam logic [14:0] BUB = 15'd0;
  localparam logic [12:0] ST0 = 13'd0;

  logic clk = 1'b0, rst = 1'b0, id_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [5:0] opcode = 6'h00, func = 6'h00;
  logic ex_valid, ex_alusrc, ex_regdst, ex_regwrite, ex_readmem;
  logic ex_writemem, ex_memtoreg, ex_branch, ex_branch_ne, ex_jump;
  logic ex_zeroext, illegal;
  logic [3:0] ex_aluop;
  logic [5:0] illegal_opcode, illegal_func;

  always #5 clk = ~clk;

  id_ex_controller #(.ALUOP_W(4), .TRAP_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .opcode(opcode), .func(func), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_aluop(ex_aluop),
    .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst),
    .ex_regwrite(ex_regwrite), .ex_readmem(ex_readmem),
    .ex_writemem(ex_writemem), .ex_memtoreg(ex_memtoreg),
    .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne),
    .ex_jump(ex_jump), .ex_zeroext(ex_zeroext),
    .illegal(illegal), .illegal_opcode(illegal_opcode),
    .illegal_func(illegal_func)
  );

  wire [27:0] obs = {ex_valid, ex_aluop, ex_alusrc, ex_regdst,
                     ex_regwrite, ex_readmem, ex_writemem, ex_memtoreg,
                     ex_branch, ex_branch_ne, ex_jump, ex_zeroext,
                     illegal, illegal_opcode, illegal_func};

  typedef struct {
    string       name;
    logic [27:0] exp;
  } sb_t;

  sb_t sb[$];
  sb_t e;
  int  nchk = 0;
  int  nfail = 0;

  function automatic logic [14:0] bnd(logic [3:0] a, logic [9:0] c);
    return {1'b1, a, c};
  endfunction

  function automatic logic [12:0] st(logic [5:0] op, logic [5:0] fn);
    return {1'b1, op, fn};
  endfunction

  // Drive one cycle of stimulus and queue what must appear after the edge.
  task automatic drive(input string nm, input logic r, v, s, f,
                       input logic [5:0] op, fn,
                       input logic [14:0] eb, input logic [12:0] es);
    rst = r; id_valid = v; stall = s; flush = f; opcode = op; func = fn;
    sb.push_back('{nm, {eb, es}});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive("reset", 1, 1, 0, 0, 6'h00, 6'h20, BUB, ST0);
    e = sb.pop_front(); nchk++;
    if (obs !== e.exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn[11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                           6'h27, 6'h00, 6'h02, 6'h03, 6'h2A};
    logic [3:0] op[11] = '{ADD, ADDU, SUB, SUBU, AND, OR,
                           NOR, SLL, SRL, SRA, SLT};
    for (int i = 0; i < 11; i++) begin
      drive($sformatf("rtype_f%h", fn[i]), 0, 1, 0, 0, 6'h00, fn[i],
            bnd(op[i], RDST | RW), ST0);
      e = sb.pop_front(); nchk++;
      if (obs !== e.exp) begin
        nfail++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  op[11] = '{6'h23, 6'h2B, 6'h05, 6'h0C, 6'h08, 6'h09,
                            6'h0A, 6'h0D, 6'h04, 6'h02, 6'h23};
    logic [14:0] ex[11];
    logic        vl;
    ex = '{bnd(ADD, SRC | RW | RM | M2R), bnd(ADD, SRC | WM),
           bnd(SUB, BR | BNE), bnd(AND, SRC | RW | ZX),
           bnd(ADD, SRC | RW), bnd(ADDU, SRC | RW), bnd(SLT, SRC | RW),
           bnd(OR, SRC | RW | ZX), bnd(SUB, BR), bnd(NOP, JMP), BUB};
    for (int i = 0; i < 11; i++) begin
      vl = (i != 10);
      drive($sformatf("b2b_op%h_v%0d", op[i], vl), 0, vl, 0, 0,
            op[i], 6'h11, ex[i], ST0);
      e = sb.pop_front(); nchk++;
      if (obs !== e.exp) begin
        nfail++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [5:0]  op[5] = '{6'h08, 6'h2B, 6'h2B, 6'h2B, 6'h2B};
    logic        sl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [14:0] ex[5];
    ex = '{bnd(ADD, SRC | RW), bnd(ADD, SRC | RW), bnd(ADD, SRC | RW),
           bnd(ADD, SRC | RW), bnd(ADD, SRC | WM)};
    for (int i = 0; i < 5; i++) begin
      drive($sformatf("stall_step%0d", i), 0, 1, sl[i], 0, op[i], 6'h00,
            ex[i], ST0);
      e = sb.pop_front(); nchk++;
      if (obs !== e.exp) begin
        nfail++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_flush();
    string       nm[5] = '{"flush_pre_add", "flush_with_stall",
                           "flush_alone", "reload_add", "reset_midstream"};
    logic        r[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        s[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        f[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [5:0]  op[5] = '{6'h00, 6'h04, 6'h04, 6'h00, 6'h00};
    logic [14:0] ex[5];
    ex = '{bnd(ADD, RDST | RW), BUB, BUB, bnd(ADD, RDST | RW), BUB};
    for (int i = 0; i < 5; i++) begin
      drive(nm[i], r[i], 1, s[i], f[i], op[i], 6'h20, ex[i], ST0);
      e = sb.pop_front(); nchk++;
      if (obs !== e.exp) begin
        nfail++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_illegal();
    string       nm[4] = '{"ill_op3f", "ill_func3e", "ill_then_add",
                           "ill_reset_clears"};
    logic        r[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [5:0]  op[4] = '{6'h3F, 6'h00, 6'h00, 6'h3F};
    logic [5:0]  fn[4] = '{6'h15, 6'h3E, 6'h20, 6'h3E};
    logic [14:0] eb[4];
    logic [12:0] es[4];
    eb = '{BUB, BUB, bnd(ADD, RDST | RW), BUB};
    es = '{st(6'h3F, 6'h00), st(6'h3F, 6'h00), st(6'h3F, 6'h00), ST0};
    for (int i = 0; i < 4; i++) begin
      drive(nm[i], r[i], 1, 0, 0, op[i], fn[i], eb[i], es[i]);
      e = sb.pop_front(); nchk++;
      if (obs !== e.exp) begin
        nfail++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_no_record();
    string       nm[5] = '{"norec_load", "norec_stall", "norec_novalid",
                           "norec_flush", "rtype_func_trap"};
    logic        v[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        s[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        f[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [5:0]  op[5] = '{6'h0D, 6'h3F, 6'h3F, 6'h3F, 6'h00};
    logic [5:0]  fn[5] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h01};
    logic [14:0] eb[5];
    logic [12:0] es[5];
    eb = '{bnd(OR, SRC | RW | ZX), bnd(OR, SRC | RW | ZX), BUB, BUB, BUB};
    es = '{ST0, ST0, ST0, ST0, st(6'h00, 6'h01)};
    for (int i = 0; i < 5; i++) begin
      drive(nm[i], 0, v[i], s[i], f[i], op[i], fn[i], eb[i], es[i]);
      e = sb.pop_front(); nchk++;
      if (obs !== e.exp) begin
        nfail++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_rtype();
    test_back_to_back();
    test_stall();
    test_flush();
    test_illegal();
    test_no_record();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
